instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, program-memory entries (power of 2).
REQ-002 Parameter WIDTH, default 11, instruction word width.
REQ-003 Parameter TIMEOUT, default 64, Done-wait watchdog limit in cycles.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin execution at address 0.
REQ-007 Done  in  1  one-cycle completion pulse from processor control circuit.
REQ-008 prog_we  in  1  program-memory write enable.
REQ-009 prog_addr  in  log2(DEPTH)  program-memory write address.
REQ-010 prog_data  in  WIDTH  program-memory write data.
REQ-011 INSTRUCTION  out  WIDTH  registered word driven to the processor.
REQ-012 pc  out  log2(DEPTH)  address of word currently on INSTRUCTION.
REQ-013 busy  out  1  high in every state except IDLE and HALTED.
REQ-014 halted  out  1  high in HALTED.
REQ-015 error  out  1  sticky fault flag, cleared by start or reset.

Function
REQ-016 Opcode = INSTRUCTION[WIDTH-1:WIDTH-3]; 3'b001 = LOAD (next word is immediate data), 3'b111 = HALT, all others = single-word ops.
REQ-017 States: IDLE, LOAD_OP, WAIT_DONE, HALTED.
REQ-018 Fetch(a): INSTRUCTION<=mem[a], pc<=a; next state LOAD_OP if LOAD, WAIT_DONE otherwise; HALT opcode instead sets INSTRUCTION<=0, state HALTED (HALT word never issued).
REQ-019 IDLE/HALTED: start=1 -> Fetch(0), error<=0, one-cycle latency start-to-valid INSTRUCTION.
REQ-020 LOAD_OP lasts exactly one cycle, then INSTRUCTION<=mem[pc+1], pc<=pc+1, state WAIT_DONE.
REQ-021 LOAD at pc=DEPTH-1: no data word exists -> error<=1, INSTRUCTION<=0, state HALTED.
REQ-022 WAIT_DONE: INSTRUCTION held stable until Done=1; then Fetch(pc+1).
REQ-023 Done in WAIT_DONE at pc=DEPTH-1 -> INSTRUCTION<=0, state HALTED, no wrap to 0.
REQ-024 Done outside WAIT_DONE is ignored; start while busy is ignored.
REQ-025 prog_we honoured only in IDLE or HALTED; writes while busy are discarded.
REQ-026 Memory is combinationally read, synchronously written; write and start on the same edge: write completes, fetch reads the pre-write contents.

Reset
REQ-027 reset=1 forces, without waiting for clk: state IDLE, INSTRUCTION=0, pc=0, busy=0, halted=0, error=0, watchdog count=0.
REQ-028 reset mid-execution abandons the current instruction; program-memory contents are not reset.
REQ-029 Deassertion of reset takes effect from the next rising edge of clk.

Configuration
REQ-030 Macro SEQ_WATCHDOG_EN compiles in the Done watchdog.
REQ-031 With SEQ_WATCHDOG_EN: counter clears on every WAIT_DONE entry, increments each WAIT_DONE cycle; reaching TIMEOUT-1 without Done -> error<=1, INSTRUCTION<=0, state HALTED.
REQ-032 With SEQ_WATCHDOG_EN: Done on the same edge as expiry wins (normal advance, no error).
REQ-033 Without SEQ_WATCHDOG_EN: no counter logic; WAIT_DONE waits indefinitely; error set only by REQ-021.

Verification
REQ-034 Load mem[0..2]={11'h010,11'h020,11'h700}, start -> INSTRUCTION 11'h010 next cycle; Done pulse -> 11'h020; Done -> INSTRUCTION=0, halted=1, pc=2.
REQ-035 mem[0]=11'h100 (LOAD), mem[1]=11'h05A, start -> 11'h100 one cycle, then 11'h05A held, pc=1, until Done.
REQ-036 16 single-word non-HALT ops, Done after each -> pc walks 0..15, halted=1 after 16th Done, INSTRUCTION=0, no wrap.
REQ-037 mem[15]=LOAD reached -> error=1, halted=1; subsequent start clears error and refetches mem[0].
REQ-038 SEQ_WATCHDOG_EN, TIMEOUT=64, withhold Done -> error=1 and halted exactly 63 cycles after WAIT_DONE entry; repeat with Done on cycle 63 -> advance, error=0.
REQ-039 reset asserted mid-WAIT_DONE between clock edges -> all outputs 0 immediately; prog_we while busy leaves mem unchanged (checked by rerun).

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues words from a small program memory to a processor,
// handshaking on Done. Define SEQ_WATCHDOG_EN to compile in the Done-wait watchdog.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 11,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     Done,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [WIDTH-1:0]         prog_data,
    output logic [WIDTH-1:0]         INSTRUCTION,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     halted,
    output logic                     error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_OP, WAIT_DONE, HALTED} state_t;

    state_t           state_q, state_d, fetch_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             error_q, error_d;
    logic [AW-1:0]    pc_next, fetch_addr;
    logic [WIDTH-1:0] fetch_word;
    logic             idle_or_halted, fetch_is_load, fetch_is_halt, pc_last, wd_expire;

    assign idle_or_halted = (state_q == IDLE) || (state_q == HALTED);
    assign pc_next        = pc_q + AW'(1);
    assign pc_last        = (pc_q == AW'(DEPTH - 1));

    // One read port serves both a fresh start (address 0) and every advance (pc+1).
    assign fetch_addr     = idle_or_halted ? '0 : pc_next;
    assign fetch_word     = mem[fetch_addr];
    assign fetch_is_load  = (fetch_word[WIDTH-1 -: 3] == 3'b001);
    assign fetch_is_halt  = (fetch_word[WIDTH-1 -: 3] == 3'b111);
    assign fetch_state    = fetch_is_halt ? HALTED : (fetch_is_load ? LOAD_OP : WAIT_DONE);

    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halted) begin
            mem[prog_addr] <= prog_data;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // Counter sits at zero outside a pending wait, so every WAIT_DONE entry starts fresh.
    assign wd_cnt_d  = (state_q == WAIT_DONE && !Done) ? wd_cnt_q + CW'(1) : '0;
    assign wd_expire = (state_q == WAIT_DONE) && !Done && (wd_cnt_q == CW'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALTED: if (start) state_d = fetch_state;
            LOAD_OP:      state_d = pc_last ? HALTED : WAIT_DONE;
            WAIT_DONE: begin
                if (Done) begin
                    state_d = pc_last ? HALTED : fetch_state;
                end else if (wd_expire) begin
                    state_d = HALTED;
                end
            end
            default:      state_d = IDLE;
        endcase
    end

    // A HALT word is never issued: the bus drops to zero instead.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        error_d = error_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    error_d = 1'b0;
                    pc_d    = fetch_addr;
                    instr_d = fetch_is_halt ? '0 : fetch_word;
                end
            end
            LOAD_OP: begin
                if (pc_last) begin
                    error_d = 1'b1;
                    instr_d = '0;
                end else begin
                    pc_d    = pc_next;
                    instr_d = fetch_word;
                end
            end
            WAIT_DONE: begin
                if (Done) begin
                    if (pc_last) begin
                        instr_d = '0;
                    end else begin
                        pc_d    = fetch_addr;
                        instr_d = fetch_is_halt ? '0 : fetch_word;
                    end
                end else if (wd_expire) begin
                    error_d = 1'b1;
                    instr_d = '0;
                end
            end
            default: begin
                instr_d = '0;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            error_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            error_q <= error_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign pc          = pc_q;
    assign error       = error_q;
    assign busy        = (state_q == LOAD_OP) || (state_q == WAIT_DONE);
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a behavioural program interpreter predicts
// every cycle's outputs, and a monitor compares them one cycle later.
module tb_instr_sequencer;
    localparam int DEPTH   = 16;
    localparam int WIDTH   = 11;
    localparam int TIMEOUT = 64;

    localparam int M_IDLE = 0;
    localparam int M_DATA = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    typedef struct {
        logic [WIDTH-1:0] instr;
        logic [3:0]       pc;
        logic             busy;
        logic             halted;
        logic             error;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             done = 1'b0;
    logic             prog_we = 1'b0;
    logic [3:0]       prog_addr = '0;
    logic [WIDTH-1:0] prog_data = '0;
    logic [WIDTH-1:0] instruction;
    logic [3:0]       pc;
    logic             busy, halted, error;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    int mem_m [DEPTH];
    int m_instr, m_pc, m_mode, m_waited, m_err;

    instr_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .Done(done),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .INSTRUCTION(instruction), .pc(pc), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_expect();
        exp_t e;
        e.instr  = WIDTH'(m_instr);
        e.pc     = 4'(m_pc);
        e.busy   = (m_mode == M_DATA) || (m_mode == M_WAIT);
        e.halted = (m_mode == M_HALT);
        e.error  = (m_err != 0);
        return e;
    endfunction

    task automatic model_reset();
        m_instr = 0; m_pc = 0; m_mode = M_IDLE; m_waited = 0; m_err = 0;
    endtask

    task automatic model_halt();
        m_instr = 0;
        m_mode  = M_HALT;
    endtask

    task automatic model_issue(input int a);
        int w, op;
        w    = mem_m[a];
        op   = (w >> 8) & 7;
        m_pc = a;
        if (op == 7) begin
            model_halt();
        end else begin
            m_instr  = w;
            m_mode   = (op == 1) ? M_DATA : M_WAIT;
            m_waited = 0;
        end
    endtask

    task automatic model_step(input bit st, input bit dn, input bit we, input int wa, input int wd);
        int was_mode;
        was_mode = m_mode;
        case (m_mode)
            M_IDLE, M_HALT: begin
                if (st) begin
                    m_err = 0;
                    model_issue(0);
                end
            end
            M_DATA: begin
                if (m_pc == DEPTH - 1) begin
                    m_err = 1;
                    model_halt();
                end else begin
                    m_pc     = m_pc + 1;
                    m_instr  = mem_m[m_pc];
                    m_mode   = M_WAIT;
                    m_waited = 0;
                end
            end
            default: begin
                if (dn) begin
                    if (m_pc == DEPTH - 1) model_halt();
                    else model_issue(m_pc + 1);
                end else begin
                    m_waited = m_waited + 1;
`ifdef SEQ_WATCHDOG_EN
                    if (m_waited == TIMEOUT - 1) begin
                        m_err = 1;
                        model_halt();
                    end
`endif
                end
            end
        endcase
        if (we && (was_mode == M_IDLE || was_mode == M_HALT)) mem_m[wa] = wd;
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        vectors++;
        if (instruction !== e.instr || pc !== e.pc || busy !== e.busy ||
            halted !== e.halted || error !== e.error) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t got instr=%h pc=%0d busy=%b halted=%b error=%b expected instr=%h pc=%0d busy=%b halted=%b error=%b",
                     tag, $time, instruction, pc, busy, halted, error,
                     e.instr, e.pc, e.busy, e.halted, e.error);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic applyStimulus(input bit st, input bit dn, input bit we, input int wa, input int wd);
        @(negedge clk);
        start     = st;
        done      = dn;
        prog_we   = we;
        prog_addr = 4'(wa);
        prog_data = WIDTH'(wd);
        model_step(st, dn, we, wa, wd);
        exp_q.push_back(model_expect());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic write_word(input int a, input int d);
        applyStimulus(0, 0, 1, a, d);
    endtask

    // Reset lands between edges so its asynchronous effect is visible before any clock.
    task automatic do_reset();
        @(negedge clk);
        start = 0; done = 0; prog_we = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        checkOutput(model_expect(), "async_reset");
        exp_q.push_back(model_expect());
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e, "cycle");
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        #2;
        checkOutput(model_expect(), "reset_at_time0");
        do_reset();

        // Two single-word ops then HALT.
        write_word(0, 'h010);
        write_word(1, 'h020);
        write_word(2, 'h700);
        for (int i = 3; i < DEPTH; i++) write_word(i, 'h000);
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(3);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(2);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(2);

        // LOAD with immediate data, held until Done.
        write_word(0, 'h100);
        write_word(1, 'h05A);
        write_word(2, 'h700);
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(4);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(2);

        // Full sweep of single-word ops; no wrap past the last address.
        for (int i = 0; i < DEPTH; i++) write_word(i, 'h200 + i);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            idle_cycles(1);
            applyStimulus(0, 1, 0, 0, 0);
        end
        idle_cycles(3);

        // LOAD in the last slot faults; a new start clears the fault.
        write_word(DEPTH - 1, 'h1FF);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(3);
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(2);

        // Busy-time writes are discarded; start while busy ignored.
        applyStimulus(0, 0, 1, 0, 'h7AA);
        applyStimulus(1, 0, 1, 1, 'h3CC);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(1);
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(1);
        do_reset();

        // Write and start on the same edge: fetch sees the old word.
        applyStimulus(1, 0, 1, 0, 'h700);
        idle_cycles(2);
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(2);
        do_reset();

        write_word(0, 'h010);
        write_word(1, 'h020);
`ifdef SEQ_WATCHDOG_EN
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(70);
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(TIMEOUT - 2);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(3);
`else
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(100);
        applyStimulus(0, 1, 0, 0, 0);
        idle_cycles(2);
`endif
        do_reset();

        // Randomised programs and handshakes.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++)
                write_word(i, ($urandom_range(0, 7) << 8) | $urandom_range(0, 255));
            applyStimulus(1, 0, 0, 0, 0);
            for (int c = 0; c < 150; c++) begin
                applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
                              $urandom_range(0, 9) == 0, $urandom_range(0, DEPTH - 1),
                              $urandom_range(0, (1 << WIDTH) - 1));
            end
            if (r % 5 == 4) do_reset();
        end

        idle_cycles(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
